// File: rtl/uart_note_sequencer.sv
// UART-driven note sequencer: parses {tone, duration} byte pairs from uart_recv,
// buffers them in a FIFO and plays them back-to-back, timed in milliseconds.
module uart_note_sequencer #(
    parameter int unsigned CLK_FREQ        = 12000000,
    parameter int unsigned FIFO_DEPTH      = 16,
    parameter int unsigned DUR_UNIT_MS     = 10,
    parameter int unsigned BYTE_TIMEOUT_MS = 50,
    parameter logic [7:0]  FLUSH_CODE      = 8'hFF
) (
    input  logic                         sys_clk,
    input  logic                         sys_rst,
    input  logic                         rx_done,
    input  logic [7:0]                   rx_data,
    input  logic                         play_en,
    output logic [7:0]                   music_tone,
    output logic                         tone_en,
    output logic                         playing,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic                         overflow,
    output logic                         blink
);

    localparam int unsigned MS_CYC = CLK_FREQ / 1000;
    localparam int unsigned TW     = (MS_CYC > 1) ? $clog2(MS_CYC) : 1;
    localparam int unsigned AW     = $clog2(FIFO_DEPTH);
    localparam int unsigned PW     = AW + 1;
    localparam int unsigned RW     = 8 + $clog2(DUR_UNIT_MS + 1);
    localparam int unsigned OW     = (BYTE_TIMEOUT_MS > 1) ? $clog2(BYTE_TIMEOUT_MS) : 1;

    typedef enum logic {
        P_WAIT_TONE,
        P_WAIT_DUR
    } pstate_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_PLAY
    } state_t;

    // Byte strobe, parser and tick state
    logic          d0_q, d1_q;
    logic [7:0]    data_q;
    logic [TW-1:0] tick_q, tick_d;
    pstate_t       pstate_q, pstate_d;
    logic [7:0]    tone_lat_q, tone_lat_d;
    logic [OW-1:0] tout_q, tout_d;
    logic          blink_q, blink_d;
    logic          overflow_q, overflow_d;

    // FIFO state; entries are {tone, dur}
    logic [15:0]   mem_q [FIFO_DEPTH];
    logic [15:0]   mem_d [FIFO_DEPTH];
    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d, count_q, count_d;

    // Player state
    state_t        state_q, state_d;
    logic [15:0]   note_q, note_d;
    logic [RW-1:0] rem_q, rem_d;
    logic [TW-1:0] pre_q, pre_d;
    logic [7:0]    music_tone_q, music_tone_d;
    logic          tone_en_q, tone_en_d;
    logic          playing_q, playing_d;

    logic          byte_stb, ms_tick, flush, push_req, push_ok, pop, full, empty;
    logic [15:0]   head;

    assign byte_stb = d0_q & ~d1_q;
    assign ms_tick  = (tick_q == TW'(MS_CYC - 1));
    assign flush    = byte_stb && (pstate_q == P_WAIT_TONE) && (data_q == FLUSH_CODE);
    assign push_req = byte_stb && (pstate_q == P_WAIT_DUR) && (data_q != 8'd0);
    assign full     = (count_q == PW'(FIFO_DEPTH));
    assign empty    = (count_q == PW'(0));
    assign push_ok  = push_req && (!full || pop);
    assign head     = mem_q[rd_q[AW-1:0]];

    // Parser, ms tick and FIFO bookkeeping
    always_comb begin
        tick_d     = ms_tick ? TW'(0) : tick_q + TW'(1);
        pstate_d   = pstate_q;
        tone_lat_d = tone_lat_q;
        tout_d     = tout_q;
        blink_d    = blink_q;
        overflow_d = overflow_q;
        mem_d      = mem_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        count_d    = count_q;

        if (byte_stb) begin
            blink_d = ~blink_q;
            case (pstate_q)
                P_WAIT_TONE: begin
                    if (data_q != FLUSH_CODE) begin
                        tone_lat_d = data_q;
                        tout_d     = OW'(0);
                        pstate_d   = P_WAIT_DUR;
                    end
                end
                P_WAIT_DUR: pstate_d = P_WAIT_TONE;
                default:    pstate_d = P_WAIT_TONE;
            endcase
        end else if ((pstate_q == P_WAIT_DUR) && ms_tick) begin
            // A tone byte left without its duration expires after the timeout
            if (tout_q == OW'(BYTE_TIMEOUT_MS - 1)) begin
                pstate_d = P_WAIT_TONE;
            end else begin
                tout_d = tout_q + OW'(1);
            end
        end

        if (push_req && !push_ok) begin
            overflow_d = 1'b1;
        end
        if (push_ok) begin
            mem_d[wr_q[AW-1:0]] = {tone_lat_q, data_q};
            wr_d = wr_q + PW'(1);
        end
        if (pop) begin
            rd_d = rd_q + PW'(1);
        end
        count_d = count_q + PW'(push_ok) - PW'(pop);

        if (flush) begin
            wr_d       = PW'(0);
            rd_d       = PW'(0);
            count_d    = PW'(0);
            overflow_d = 1'b0;
        end
    end

    // Player: pop a note, load its length, count it down in unpaused milliseconds
    always_comb begin
        state_d      = state_q;
        note_d       = note_q;
        rem_d        = rem_q;
        pre_d        = pre_q;
        music_tone_d = music_tone_q;
        tone_en_d    = tone_en_q;
        pop          = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (play_en && !empty) begin
                    pop     = 1'b1;
                    note_d  = head;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                music_tone_d = note_q[15:8];
                tone_en_d    = (note_q[15:8] != 8'd0);
                rem_d        = RW'(note_q[7:0]) * RW'(DUR_UNIT_MS);
                pre_d        = TW'(0);
                state_d      = S_PLAY;
            end
            S_PLAY: begin
                tone_en_d = play_en && (music_tone_q != 8'd0);
                if (play_en) begin
                    if (pre_q == TW'(MS_CYC - 1)) begin
                        pre_d = TW'(0);
                        rem_d = rem_q - RW'(1);
                        if (rem_q == RW'(1)) begin
                            if (!empty) begin
                                // Gapless hand-off: current tone stays up through LOAD
                                pop     = 1'b1;
                                note_d  = head;
                                state_d = S_LOAD;
                            end else begin
                                music_tone_d = 8'd0;
                                tone_en_d    = 1'b0;
                                state_d      = S_IDLE;
                            end
                        end
                    end else begin
                        pre_d = pre_q + TW'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (flush) begin
            state_d      = S_IDLE;
            music_tone_d = 8'd0;
            tone_en_d    = 1'b0;
        end

        playing_d = (state_d != S_IDLE);
    end

    // State registers with synchronous reset
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            d0_q         <= 1'b0;
            d1_q         <= 1'b0;
            data_q       <= 8'd0;
            tick_q       <= TW'(0);
            pstate_q     <= P_WAIT_TONE;
            tone_lat_q   <= 8'd0;
            tout_q       <= OW'(0);
            blink_q      <= 1'b0;
            overflow_q   <= 1'b0;
            wr_q         <= PW'(0);
            rd_q         <= PW'(0);
            count_q      <= PW'(0);
            state_q      <= S_IDLE;
            note_q       <= 16'd0;
            rem_q        <= RW'(0);
            pre_q        <= TW'(0);
            music_tone_q <= 8'd0;
            tone_en_q    <= 1'b0;
            playing_q    <= 1'b0;
        end else begin
            d0_q         <= rx_done;
            d1_q         <= d0_q;
            data_q       <= rx_data;
            tick_q       <= tick_d;
            pstate_q     <= pstate_d;
            tone_lat_q   <= tone_lat_d;
            tout_q       <= tout_d;
            blink_q      <= blink_d;
            overflow_q   <= overflow_d;
            wr_q         <= wr_d;
            rd_q         <= rd_d;
            count_q      <= count_d;
            state_q      <= state_d;
            note_q       <= note_d;
            rem_q        <= rem_d;
            pre_q        <= pre_d;
            music_tone_q <= music_tone_d;
            tone_en_q    <= tone_en_d;
            playing_q    <= playing_d;
        end
    end

    // FIFO storage; contents need no reset since pointers gate every read
    always_ff @(posedge sys_clk) begin
        mem_q <= mem_d;
    end

    assign music_tone = music_tone_q;
    assign tone_en    = tone_en_q;
    assign playing    = playing_q;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;
    assign blink      = blink_q;

endmodule

// File: tb/tb_uart_note_sequencer.sv
// Bench for uart_note_sequencer: 100 cycles per ms, 1 ms duration unit, 4-entry FIFO.
module tb_uart_note_sequencer;

    localparam int CYC_MS = 100;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b1;
    logic       rx_done = 1'b0;
    logic [7:0] rx_data = 8'd0;
    logic       play_en = 1'b0;
    logic [7:0] music_tone;
    logic       tone_en;
    logic       playing;
    logic [2:0] fifo_count;
    logic       overflow;
    logic       blink;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [7:0] tone;
        logic [7:0] dur;
    } note_t;

    typedef struct {
        logic [7:0] tone;
        logic [7:0] dur;
        int         exp_cnt;
        int         exp_ovf;
    } vec_t;

    typedef struct {
        int tone;
        int len;
        int en;
    } run_t;

    note_t exp_q[$];
    run_t  runs[$];

    uart_note_sequencer #(
        .CLK_FREQ(100000),
        .FIFO_DEPTH(4),
        .DUR_UNIT_MS(1),
        .BYTE_TIMEOUT_MS(50),
        .FLUSH_CODE(8'hFF)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .rx_done(rx_done),
        .rx_data(rx_data),
        .play_en(play_en),
        .music_tone(music_tone),
        .tone_en(tone_en),
        .playing(playing),
        .fifo_count(fifo_count),
        .overflow(overflow),
        .blink(blink)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // One low cycle, then rx_done high for 'hold' cycles; returns right after the accepting edge when hold=2
    task automatic send_byte(input logic [7:0] b, input int hold);
        rx_done = 1'b0;
        @(negedge sys_clk);
        rx_done = 1'b1;
        rx_data = b;
        repeat (hold) @(negedge sys_clk);
        rx_done = 1'b0;
    endtask

    task automatic send_pair(input logic [7:0] t, input logic [7:0] d);
        note_t n;
        send_byte(t, 2);
        send_byte(d, 2);
        if (d != 8'd0 && exp_q.size() < 4) begin
            n.tone = t;
            n.dur  = d;
            exp_q.push_back(n);
        end
    endtask

    // Record tone runs from the first PLAY cycle until playing drops, then score them against exp_q
    task automatic rec_runs(input int budget);
        int   n = 0;
        int   cur;
        int   len = 0;
        int   enc = 0;
        run_t r;
        note_t e;
        int   exp_len;
        runs.delete();
        while (!playing && n < budget) begin
            @(negedge sys_clk);
            n++;
        end
        if (!playing) begin
            check("play_start", 0, 1);
            return;
        end
        @(negedge sys_clk);
        cur = int'(music_tone);
        while (playing && n < budget) begin
            if (int'(music_tone) != cur) begin
                r.tone = cur; r.len = len; r.en = enc;
                runs.push_back(r);
                cur = int'(music_tone); len = 0; enc = 0;
            end
            len++;
            if (tone_en) enc++;
            @(negedge sys_clk);
            n++;
        end
        r.tone = cur; r.len = len; r.en = enc;
        runs.push_back(r);
        check("play_end_in_budget", int'(playing), 0);
        check("idle_tone", int'(music_tone), 0);
        check("idle_tone_en", int'(tone_en), 0);
        check("run_count", runs.size(), exp_q.size());
        for (int i = 0; i < runs.size(); i++) begin
            if (exp_q.size() == 0) break;
            e = exp_q.pop_front();
            // every note but the last also covers the LOAD cycle of its successor
            exp_len = int'(e.dur) * CYC_MS + ((i < runs.size() - 1) ? 1 : 0);
            check("run_tone", runs[i].tone, int'(e.tone));
            check("run_len", runs[i].len, exp_len);
            check("run_en", runs[i].en, (e.tone != 8'd0) ? exp_len : 0);
        end
    endtask

    initial begin
        vec_t vecs[7];
        int   b0;
        int   cyc;
        int   enc;
        note_t e;

        vecs[0] = '{8'd1, 8'd1,   1, 0};
        vecs[1] = '{8'd2, 8'd0,   1, 0};
        vecs[2] = '{8'd0, 8'd2,   2, 0};
        vecs[3] = '{8'd3, 8'd3,   3, 0};
        vecs[4] = '{8'd4, 8'd4,   4, 0};
        vecs[5] = '{8'd5, 8'd5,   4, 1};
        vecs[6] = '{8'd6, 8'd255, 4, 1};

        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        check("rst_tone", int'(music_tone), 0);
        check("rst_tone_en", int'(tone_en), 0);
        check("rst_playing", int'(playing), 0);
        check("rst_count", int'(fifo_count), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_blink", int'(blink), 0);

        // Single note, immediate playback
        play_en = 1'b1;
        b0 = int'(blink);
        send_byte(8'h05, 2);
        check("t1_blink1", int'(blink), 1 - b0);
        send_byte(8'h03, 2);
        e.tone = 8'h05; e.dur = 8'h03;
        exp_q.push_back(e);
        check("t1_count_push", int'(fifo_count), 1);
        check("t1_blink2", int'(blink), b0);
        @(negedge sys_clk);
        check("t1_count_pop", int'(fifo_count), 0);
        rec_runs(1000);

        // Gapless three-note sequence including a rest
        play_en = 1'b0;
        send_pair(8'd3, 8'd2);
        send_pair(8'd0, 8'd1);
        send_pair(8'd7, 8'd1);
        check("t2_count", int'(fifo_count), 3);
        check("t2_not_playing", int'(playing), 0);
        play_en = 1'b1;
        rec_runs(2000);
        play_en = 1'b0;

        // Fill, overflow, discard of zero duration, then flush
        for (int i = 0; i < 7; i++) begin
            send_pair(vecs[i].tone, vecs[i].dur);
            check($sformatf("t3_count_%0d", i), int'(fifo_count), vecs[i].exp_cnt);
            check($sformatf("t3_ovf_%0d", i), int'(overflow), vecs[i].exp_ovf);
        end
        send_byte(8'hFF, 2);
        exp_q.delete();
        check("t3_flush_count", int'(fifo_count), 0);
        check("t3_flush_ovf", int'(overflow), 0);
        check("t3_flush_playing", int'(playing), 0);

        // Tone byte times out; the next two bytes form a fresh pair
        send_byte(8'h09, 2);
        repeat (5100) @(negedge sys_clk);
        send_byte(8'h04, 2);
        check("t4_tone_only", int'(fifo_count), 0);
        send_byte(8'h02, 2);
        check("t4_pair", int'(fifo_count), 1);
        e.tone = 8'h04; e.dur = 8'h02;
        exp_q.push_back(e);
        play_en = 1'b1;
        rec_runs(1000);
        play_en = 1'b0;

        // Pause in the middle of a note
        send_pair(8'd6, 8'd4);
        play_en = 1'b1;
        cyc = 0;
        while (!tone_en && cyc < 20) begin
            @(negedge sys_clk);
            cyc++;
        end
        check("t5_start", int'(tone_en), 1);
        e = exp_q.pop_front();
        cyc = 0;
        enc = 0;
        while (playing && cyc < 1000) begin
            if (tone_en) enc++;
            if (cyc == 150) begin
                check("t5_paused_en", int'(tone_en), 0);
                check("t5_paused_tone", int'(music_tone), int'(e.tone));
            end
            if (cyc == 100) play_en = 1'b0;
            if (cyc == 250) play_en = 1'b1;
            @(negedge sys_clk);
            cyc++;
        end
        check("t5_note_span", cyc, 550);
        check("t5_en_cycles", enc, int'(e.dur) * CYC_MS);
        play_en = 1'b0;

        // Reset mid-note, then a long rx_done pulse
        send_pair(8'd8, 8'd5);
        send_pair(8'd2, 8'd3);
        play_en = 1'b1;
        cyc = 0;
        while (!tone_en && cyc < 20) begin
            @(negedge sys_clk);
            cyc++;
        end
        repeat (CYC_MS) @(negedge sys_clk);
        check("t6_pre_tone", int'(music_tone), 8);
        check("t6_pre_count", int'(fifo_count), 1);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        check("t6_rst_tone", int'(music_tone), 0);
        check("t6_rst_tone_en", int'(tone_en), 0);
        check("t6_rst_playing", int'(playing), 0);
        check("t6_rst_count", int'(fifo_count), 0);
        check("t6_rst_ovf", int'(overflow), 0);
        check("t6_rst_blink", int'(blink), 0);
        sys_rst = 1'b0;
        play_en = 1'b0;
        exp_q.delete();
        send_byte(8'h11, 10);
        check("t6_long_blink", int'(blink), 1);
        repeat (5) @(negedge sys_clk);
        check("t6_long_blink_hold", int'(blink), 1);
        check("t6_long_count", int'(fifo_count), 0);
        send_byte(8'h01, 2);
        check("t6_pair_count", int'(fifo_count), 1);
        check("t6_pair_blink", int'(blink), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
